// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned STREAK_W   = 4;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'b00,
    OWN_FETCH = 2'b01,
    OWN_DATA  = 2'b10
  } rsp_owner_e;

  typedef enum logic {
    DATA_PRI    = 1'b0,
    FETCH_FORCE = 1'b1
  } arb_state_e;

  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] cur,
                                                     input logic [STREAK_W-1:0] limit);
    return (cur < limit) ? cur + 4'd1 : cur;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rsp_router.sv
// Tracks which port owns the in-flight read and steers mem_rdata back to it.
module mem_rsp_router
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              f_gnt_i,
  input  logic              d_gnt_i,
  input  logic              d_we_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              f_rvalid_o,
  output logic [DATA_W-1:0] f_rdata_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o
);

  rsp_owner_e        owner_q, owner_d;
  logic [DATA_W-1:0] f_rdata_q, d_rdata_q;

  always_comb begin
    owner_d = OWN_NONE;
    if (f_gnt_i)                owner_d = OWN_FETCH;
    else if (d_gnt_i && !d_we_i) owner_d = OWN_DATA;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q   <= OWN_NONE;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      if (owner_q == OWN_FETCH) f_rdata_q <= mem_rdata_i;
      if (owner_q == OWN_DATA)  d_rdata_q <= mem_rdata_i;
    end
  end

  // Memory data arrives the cycle after the grant; the owner sees it live,
  // the holding register keeps it for later cycles.
  assign f_rvalid_o = (owner_q == OWN_FETCH);
  assign d_rvalid_o = (owner_q == OWN_DATA);
  assign f_rdata_o  = f_rvalid_o ? mem_rdata_i : f_rdata_q;
  assign d_rdata_o  = d_rvalid_o ? mem_rdata_i : d_rdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data accesses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              halted,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                f_elig, d_elig;

  assign f_elig = f_req && !halted;
  assign d_elig = d_req;

  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset) begin
      unique case (state_q)
        DATA_PRI: begin
          if (d_elig)      d_gnt = 1'b1;
          else if (f_elig) f_gnt = 1'b1;
        end
        FETCH_FORCE: begin
          if (f_elig)      f_gnt = 1'b1;
          else if (d_elig) d_gnt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (f_gnt || !f_elig) streak_d = '0;
    else if (d_gnt)       streak_d = streak_inc(streak_q, STREAK_MAX);

    state_d = state_q;
    unique case (state_q)
      DATA_PRI:    if (streak_d == STREAK_MAX) state_d = FETCH_FORCE;
      FETCH_FORCE: if (f_gnt || !f_elig)       state_d = DATA_PRI;
      default:                                 state_d = DATA_PRI;
    endcase
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      state_q  <= DATA_PRI;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    mem_en    = f_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt) begin
      mem_addr = f_addr;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  assign stall_if = f_req && !f_gnt && !halted;

  mem_rsp_router #(
    .DATA_W(DATA_W)
  ) u_rsp_router (
    .clk_i      (clk1),
    .rst_ni     (reset),
    .f_gnt_i    (f_gnt),
    .d_gnt_i    (d_gnt),
    .d_we_i     (d_we),
    .mem_rdata_i(mem_rdata),
    .f_rvalid_o (f_rvalid),
    .f_rdata_o  (f_rdata),
    .d_rvalid_o (d_rvalid),
    .d_rdata_o  (d_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural model checked every cycle.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;

  logic        clk1 = 1'b0;
  logic        reset = 1'b0;
  logic        halted = 1'b0;
  logic        f_req = 1'b0;
  logic [7:0]  f_addr = '0;
  logic        f_gnt, f_rvalid;
  logic [31:0] f_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [7:0]  d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        stall_if;

  always #5 clk1 = ~clk1;

  mem_port_arbiter #(
    .ADDR_W(8),
    .DATA_W(32),
    .MAX_STREAK(MAXS)
  ) dut (
    .clk1(clk1), .reset(reset), .halted(halted),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if)
  );

  // Synchronous single-port memory; word i starts as 0x10000000 + i*0x11.
  logic [31:0] mem_arr [256];
  logic        mem_init_done = 1'b0;
  always @(posedge clk1) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h1000_0000 + 32'(i) * 32'h11;
      mem_init_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: fetch is forced once MAXS data grants have gone by while it waited.
  int          waits = 0;
  int          pend = 0;          // 0 none, 1 fetch, 2 data
  logic [31:0] pend_data = '0;
  logic [31:0] f_hold = '0;
  logic [31:0] d_hold = '0;

  task automatic model_step();
    logic fel, del, ef, ed;
    logic [7:0] ea;
    logic [31:0] efd, edd;
    fel = f_req && !halted;
    del = d_req;
    ef  = reset && fel && (!del || waits >= MAXS);
    ed  = reset && del && !ef;
    ea  = ef ? f_addr : d_addr;
    efd = !reset ? 32'h0 : (pend == 1 ? pend_data : f_hold);
    edd = !reset ? 32'h0 : (pend == 2 ? pend_data : d_hold);

    chk("f_gnt",    32'(f_gnt),    32'(ef));
    chk("d_gnt",    32'(d_gnt),    32'(ed));
    chk("mem_en",   32'(mem_en),   32'(ef | ed));
    chk("mem_we",   32'(mem_we),   32'(ed & d_we));
    chk("stall_if", 32'(stall_if), 32'(f_req && !ef && !halted));
    chk("f_rvalid", 32'(f_rvalid), 32'(reset && pend == 1));
    chk("d_rvalid", 32'(d_rvalid), 32'(reset && pend == 2));
    chk("f_rdata",  f_rdata, efd);
    chk("d_rdata",  d_rdata, edd);
    if (ef || ed) chk("mem_addr", 32'(mem_addr), 32'(ea));
    if (ed && d_we) chk("mem_wdata", mem_wdata, d_wdata);

    if (!reset) begin
      waits = 0; pend = 0; f_hold = '0; d_hold = '0;
    end else begin
      if (pend == 1) f_hold = pend_data;
      if (pend == 2) d_hold = pend_data;
      waits = (fel && ed) ? ((waits < MAXS) ? waits + 1 : waits) : 0;
      pend  = ef ? 1 : ((ed && !d_we) ? 2 : 0);
      pend_data = mem_arr[ea];
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic stimulus();
    repeat (3) tick();
    reset = 1'b1;

    // Fetch-only stream
    for (int a = 0; a < 4; a++) begin
      f_req = 1'b1; f_addr = 8'(a);
      @(negedge clk1);
      chk("t1_fgnt", 32'(f_gnt), 32'd1);
      chk("t1_stall", 32'(stall_if), 32'd0);
      if (a > 0) chk("t1_frdata", f_rdata, 32'h1000_0000 + 32'(a - 1) * 32'h11);
      tick();
    end
    f_req = 1'b0;
    @(negedge clk1);
    chk("t1_frvalid", 32'(f_rvalid), 32'd1);
    chk("t1_frdata3", f_rdata, 32'h1000_0033);
    tick();

    // Store then load at the same address
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 32'hDEADBEEF;
    @(negedge clk1);
    chk("t2_memwe", 32'(mem_we), 32'd1);
    tick();
    d_we = 1'b0;
    @(negedge clk1);
    chk("t2_store_norv", 32'(d_rvalid), 32'd0);
    chk("t2_ld_gnt", 32'(d_gnt), 32'd1);
    tick();
    d_req = 1'b0;
    @(negedge clk1);
    chk("t2_drvalid", 32'(d_rvalid), 32'd1);
    chk("t2_drdata", d_rdata, 32'hDEADBEEF);
    tick();

    // Both requesting continuously: D,D,D,D,F repeating
    f_req = 1'b1; f_addr = 8'd20; d_req = 1'b1; d_we = 1'b0; d_addr = 8'd30;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk1);
      chk("t3_pattern", 32'(f_gnt), (i % 5 == 4) ? 32'd1 : 32'd0);
      chk("t3_stall", 32'(stall_if), (i % 5 == 4) ? 32'd0 : 32'd1);
      if (i == 5) chk("t3_frvalid", 32'(f_rvalid), 32'd1);
      tick();
    end
    f_req = 1'b0; d_req = 1'b0;
    @(negedge clk1);
    tick();

    // Halt in the middle of a streak
    f_req = 1'b1; f_addr = 8'd50; d_req = 1'b1; d_addr = 8'd60;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk1);
      chk("t4_pre_dgnt", 32'(d_gnt), 32'd1);
      tick();
    end
    halted = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_req = (i % 2 == 0);
      @(negedge clk1);
      chk("t4_halt_fgnt", 32'(f_gnt), 32'd0);
      chk("t4_halt_stall", 32'(stall_if), 32'd0);
      chk("t4_halt_dgnt", 32'(d_gnt), 32'(d_req));
      tick();
    end
    halted = 1'b0; d_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk1);
      chk("t4_resume", 32'(f_gnt), (i == 4) ? 32'd1 : 32'd0);
      tick();
    end
    f_req = 1'b0; d_req = 1'b0;
    @(negedge clk1);
    tick();

    // Reset pulse right after a load grant
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'd5;
    @(negedge clk1);
    chk("t5_dgnt", 32'(d_gnt), 32'd1);
    tick();
    reset = 1'b0; d_req = 1'b0;
    @(negedge clk1);
    chk("t5_rst_drv", 32'(d_rvalid), 32'd0);
    chk("t5_rst_drd", d_rdata, 32'd0);
    chk("t5_rst_frd", f_rdata, 32'd0);
    chk("t5_rst_en", 32'(mem_en), 32'd0);
    tick();
    reset = 1'b1;
    @(negedge clk1);
    chk("t5_post_drv", 32'(d_rvalid), 32'd0);
    tick();
    f_req = 1'b1; f_addr = 8'd7; d_req = 1'b1; d_addr = 8'd9;
    @(negedge clk1);
    chk("t5_first_d", 32'(d_gnt), 32'd1);
    chk("t5_first_f", 32'(f_gnt), 32'd0);
    tick();
    f_req = 1'b0; d_req = 1'b0;
    @(negedge clk1);
    tick();

    // Simultaneous load and fetch to address 5 in FETCH_FORCE
    f_req = 1'b1; f_addr = 8'd5; d_req = 1'b1; d_we = 1'b0; d_addr = 8'd40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk1);
      chk("t6_dgnt", 32'(d_gnt), 32'd1);
      tick();
    end
    d_addr = 8'd5;
    @(negedge clk1);
    chk("t6_force_f", 32'(f_gnt), 32'd1);
    chk("t6_force_d", 32'(d_gnt), 32'd0);
    tick();
    f_req = 1'b0;
    @(negedge clk1);
    chk("t6_then_d", 32'(d_gnt), 32'd1);
    chk("t6_frvalid", 32'(f_rvalid), 32'd1);
    chk("t6_frdata", f_rdata, 32'h1000_0055);
    tick();
    d_req = 1'b0;
    @(negedge clk1);
    chk("t6_drvalid", 32'(d_rvalid), 32'd1);
    chk("t6_drdata", d_rdata, 32'h1000_0055);
    tick();
    @(negedge clk1);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk1);
        model_step();
      end
      stimulus();
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single unified 256x32 memory between the instruction-fetch port (IF stage) and the data port (MEM stage Load/Store).
- Decides one access per cycle, drives the memory's single synchronous port, and routes read data back to the port that issued the read.
- Data accesses normally win; a streak counter forces a fetch grant so instruction fetch is never starved.
- Raises stall_if to the pipeline whenever a fetch request is pending but not granted.

Parameters:
- ADDR_W, 8, memory word-address width (256 words).
- DATA_W, 32, data/instruction word width.
- MAX_STREAK, 4, consecutive data grants allowed while a fetch waits before fetch is forced; legal range 1..15.

Ports:
- clk1  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- halted  in  1  processor halted flag; blocks new fetch grants.
- f_req  in  1  fetch read request; held with f_addr until f_gnt.
- f_addr  in  ADDR_W  fetch word address (PC).
- f_gnt  out  1  fetch accepted this cycle (combinational).
- f_rvalid  out  1  f_rdata valid (one cycle after f_gnt).
- f_rdata  out  DATA_W  instruction word.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt.
- d_we  in  1  1 = Store, 0 = Load.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data accepted this cycle (combinational).
- d_rvalid  out  1  d_rdata valid (one cycle after a granted Load).
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0.
- stall_if  out  1  f_req && !f_gnt && !halted.

Behaviour:
- Reset (reset=0, asynchronous):
  - Registered state cleared: streak=0, FSM=DATA_PRI, rsp_owner=NONE.
  - f_rvalid, d_rvalid = 0; f_rdata, d_rdata = 0.
  - While reset is low, all combinational grants and memory strobes are forced to 0: f_gnt, d_gnt, mem_en, mem_we = 0.
  - Reset asserted mid-operation drops any in-flight read response; no rvalid is produced for it after reset releases.
- Eligibility:
  - fetch eligible = f_req && !halted.
  - data eligible = d_req.
- FSM states:
  - DATA_PRI: data wins if eligible, else fetch wins if eligible.
  - FETCH_FORCE: fetch wins if eligible, else data wins if eligible.
- Streak counter (width 4, saturating at MAX_STREAK):
  - Increment when d_gnt and fetch eligible.
  - Clear when f_gnt or fetch not eligible.
- Transitions:
  - DATA_PRI -> FETCH_FORCE when the next streak value == MAX_STREAK.
  - FETCH_FORCE -> DATA_PRI on f_gnt or when fetch is no longer eligible.
- Memory drive: at most one grant per cycle.
  - Granted port's address, we and wdata pass straight through to mem_*; mem_en = f_gnt | d_gnt.
  - Fetch grants always drive mem_we = 0.
- Read response, latency exactly 1 cycle:
  - rsp_owner registers FETCH on f_gnt, DATA on d_gnt with d_we=0, else NONE.
  - Next cycle: owner's rvalid = 1 and its rdata = mem_rdata, registered.
  - Non-owner rvalid = 0; rdata holds its last value.
- Stores: d_gnt with d_we=1 produces no d_rvalid.
  - A Load at address A granted the cycle after a Store to A returns the new data (memory write-before-read is the memory's contract; the arbiter adds no bypass).
- Throughput: back-to-back grants every cycle, no bubbles.
- Halt: asserting halted mid-streak clears streak next edge and returns the FSM to DATA_PRI. Data accesses continue to be served while halted.
- Request stability: requesters must not change address or data while req is high and gnt is low. This is an assertion target, not arbiter-enforced.

Decomposition:
- Shared package holds:
  - owner encoding: NONE=2'b00, FETCH=2'b01, DATA=2'b10.
  - FSM state encoding: DATA_PRI=1'b0, FETCH_FORCE=1'b1.
  - Default widths ADDR_W=8, DATA_W=32.
- One natural sub-module: mem_rsp_router (registered rsp_owner plus rvalid/rdata demux). Arbitration FSM and streak counter stay in the top module.

Test Plan:
- Fetch-only stream, f_addr 0,1,2,3 held one cycle each: f_gnt=1 every cycle; f_rvalid=1 with mem[0..3] on cycles 1-4; stall_if never asserts.
- Store d_addr=8'h10, d_wdata=32'hDEADBEEF, then Load 8'h10: mem_we=1 on the store cycle; d_rvalid with 32'hDEADBEEF two cycles after the store grant; no d_rvalid for the store.
- f_req and d_req held high continuously, MAX_STREAK=4: grant pattern D,D,D,D,F repeating; stall_if high on each D cycle; f_rvalid the cycle after each F.
- halted=1 with f_req=1 and d_req pulsed: f_gnt=0 throughout; stall_if=0; data still served; streak stays 0.
- Reset pulsed low in the cycle after a Load grant: d_rvalid=0 during and after reset; all outputs 0; first post-reset grant goes to data if both request.
- Simultaneous Load (d_addr=5) and fetch (f_addr=5) in FETCH_FORCE: fetch granted first, data next cycle; both rvalids carry mem[5], on consecutive cycles.
